// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared SRAM widths, owner encoding and return-tag layout
// used by the request multiplexer and the return router.
package sram_port_pkg;
   localparam int DATA_W = 1536;
   localparam int ADDR_W = 19;
   typedef enum logic {OWNER_2 = 1'b0, OWNER_1 = 1'b1} owner_t;
   typedef struct packed {
      logic                valid;
      owner_t              owner;
      logic [ADDR_W-1:0]   addr;
   } ret_tag_t;
endpackage

// File: rtl/sram_return_router_if.sv
// sram_return_router_if: muxed SRAM request/read-data inputs and the per-client
// return outputs of the router.
interface sram_return_router_if;
   import sram_port_pkg::*;
   logic              init;
   logic              read_enable;
   logic              write_enable;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] sram_read_data;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic [ADDR_W-1:0] read_address1;
   logic [ADDR_W-1:0] read_address2;
   logic              read_valid1;
   logic              read_valid2;
   logic              write_ack1;
   logic              write_ack2;
   logic [3:0]        pending;
   logic              idle;
   logic              conflict;
   modport master (
      output init, read_enable, write_enable, address, sram_read_data,
      input  read_data1, read_data2, read_address1, read_address2,
             read_valid1, read_valid2, write_ack1, write_ack2, pending, idle, conflict
   );
   modport slave (
      input  init, read_enable, write_enable, address, sram_read_data,
      output read_data1, read_data2, read_address1, read_address2,
             read_valid1, read_valid2, write_ack1, write_ack2, pending, idle, conflict
   );
endinterface

// File: rtl/latency_tag_pipe.sv
// latency_tag_pipe: DEPTH-stage shift register of return tags; tag_out is the
// tag whose SRAM data is on the bus this cycle.
module latency_tag_pipe
   import sram_port_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  ret_tag_t tag_in,
   output ret_tag_t tag_out
);
   ret_tag_t stage [DEPTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/sram_return_router.sv
// sram_return_router: routes each SRAM read word back to the client that issued
// it, acks writes per client and tracks reads in flight.
module sram_return_router
   import sram_port_pkg::*;
#(
   parameter int DATA_W       = sram_port_pkg::DATA_W,
   parameter int ADDR_W       = sram_port_pkg::ADDR_W,
   parameter int READ_LATENCY = 2
) (
   input logic                 clk,
   input logic                 rst,
   sram_return_router_if.slave bus
);
   if (DATA_W != sram_port_pkg::DATA_W || ADDR_W != sram_port_pkg::ADDR_W)
      $error("widths must match sram_port_pkg");
   if (READ_LATENCY < 1 || READ_LATENCY > 8)
      $error("READ_LATENCY must be 1..8");
   ret_tag_t   tag_in;
   ret_tag_t   tag_out;
   logic       retire;
   logic       wr_q;
   owner_t     wr_owner;
   logic [3:0] pend_next;
   always_comb begin
      tag_in    = '{valid: bus.read_enable, owner: bus.init ? OWNER_1 : OWNER_2, addr: bus.address};
      retire    = tag_out.valid;
      pend_next = bus.pending + 4'(bus.read_enable) - 4'(retire);
   end
   latency_tag_pipe #(.DEPTH(READ_LATENCY)) pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.read_data1    <= '0;
         bus.read_data2    <= '0;
         bus.read_address1 <= '0;
         bus.read_address2 <= '0;
         bus.read_valid1   <= 1'b0;
         bus.read_valid2   <= 1'b0;
         bus.write_ack1    <= 1'b0;
         bus.write_ack2    <= 1'b0;
         bus.pending       <= '0;
         bus.idle          <= 1'b1;
         bus.conflict      <= 1'b0;
         wr_q              <= 1'b0;
         wr_owner          <= OWNER_2;
      end else begin
         bus.read_valid1 <= retire && tag_out.owner == OWNER_1;
         bus.read_valid2 <= retire && tag_out.owner == OWNER_2;
         if (retire && tag_out.owner == OWNER_1) begin
            bus.read_data1    <= bus.sram_read_data;
            bus.read_address1 <= tag_out.addr;
         end
         if (retire && tag_out.owner == OWNER_2) begin
            bus.read_data2    <= bus.sram_read_data;
            bus.read_address2 <= tag_out.addr;
         end
         // a write that collides with a read is never acked
         wr_q           <= bus.write_enable && !bus.read_enable;
         wr_owner       <= bus.init ? OWNER_1 : OWNER_2;
         bus.write_ack1 <= wr_q && wr_owner == OWNER_1;
         bus.write_ack2 <= wr_q && wr_owner == OWNER_2;
         bus.pending    <= pend_next;
         bus.idle       <= pend_next == 4'd0;
         bus.conflict   <= bus.conflict || (bus.read_enable && bus.write_enable);
      end
   end
endmodule

// File: tb/tb_sram_return_router.sv
// tb_sram_return_router: scoreboard plus table-driven checks of the SRAM return router.
module tb_sram_return_router;
   localparam int L = 2;
   typedef struct {
      int          due;
      logic        own1;
      logic [18:0] a;
      logic [1535:0] d;
   } exp_t;
   typedef struct {
      logic        re, we, in;
      logic [18:0] a;
      logic [3:0]  pend;
      logic        ack1, ack2;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int passes = 0;
   exp_t q[$];
   vec_t tbl[12];
   logic [1535:0] m_d1 = '0, m_d2 = '0;
   logic [18:0]   m_a1 = '0, m_a2 = '0;
   logic [18:0]   sq0 = '0, sq1 = '0;
   sram_return_router_if bus ();
   sram_return_router #(.READ_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [1535:0] pat(input logic [18:0] a);
      return {192{8'hA5}} ^ {1517'(0), a} ^ (1536'(a) << 1000);
   endfunction
   always @(posedge clk) begin
      sq0 <= bus.address;
      sq1 <= sq0;
   end
   assign bus.sram_read_data = pat(sq1);
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
   endtask
   task automatic chkw(input string n, input logic [1535:0] act, input logic [1535:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got ..%h expected ..%h (cycle %0d)", n, act[63:0], exp[63:0], cyc);
   endtask
   always @(negedge clk) begin
      logic e1, e2;
      int p;
      e1 = q.size() > 0 && q[0].due == cyc && q[0].own1;
      e2 = q.size() > 0 && q[0].due == cyc && !q[0].own1;
      if (e1) begin m_d1 = q[0].d; m_a1 = q[0].a; end
      if (e2) begin m_d2 = q[0].d; m_a2 = q[0].a; end
      if (e1 || e2) void'(q.pop_front());
      p = 0;
      foreach (q[i]) if (q[i].due - L <= cyc) p++;
      chk("read_valid1", 64'(bus.read_valid1), 64'(e1));
      chk("read_valid2", 64'(bus.read_valid2), 64'(e2));
      chkw("read_data1", bus.read_data1, m_d1);
      chkw("read_data2", bus.read_data2, m_d2);
      chk("read_address1", 64'(bus.read_address1), 64'(m_a1));
      chk("read_address2", 64'(bus.read_address2), 64'(m_a2));
      chk("pending", 64'(bus.pending), 64'(p));
      chk("idle", 64'(bus.idle), 64'(p == 0));
   end
   task automatic drv(input logic re, input logic we, input logic in, input logic [18:0] a);
      bus.read_enable  = re;
      bus.write_enable = we;
      bus.init         = in;
      bus.address      = a;
      if (re) q.push_back('{cyc + 1 + L, in, a, pat(a)});
      @(negedge clk);
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 50) begin
         drv(0, 0, 0, '0);
         n++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask
   initial begin
      bus.read_enable  = 1'b0;
      bus.write_enable = 1'b0;
      bus.init         = 1'b0;
      bus.address      = '0;
      tbl[0]  = '{1, 0, 1, 19'h0, 4'd1, 0, 0};
      tbl[1]  = '{1, 0, 0, 19'h1, 4'd2, 0, 0};
      tbl[2]  = '{1, 0, 1, 19'h2, 4'd2, 0, 0};
      tbl[3]  = '{1, 0, 0, 19'h3, 4'd2, 0, 0};
      tbl[4]  = '{0, 0, 0, 19'h0, 4'd1, 0, 0};
      tbl[5]  = '{0, 0, 0, 19'h0, 4'd0, 0, 0};
      tbl[6]  = '{0, 1, 0, 19'h5, 4'd0, 0, 0};
      tbl[7]  = '{0, 0, 0, 19'h0, 4'd0, 0, 1};
      tbl[8]  = '{0, 1, 1, 19'h7, 4'd0, 0, 0};
      tbl[9]  = '{1, 0, 1, 19'h9, 4'd1, 1, 0};
      tbl[10] = '{0, 0, 0, 19'h0, 4'd1, 0, 0};
      tbl[11] = '{0, 0, 0, 19'h0, 4'd0, 0, 0};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         drv(0, 0, 0, '0);
         chk("rst_ack1", 64'(bus.write_ack1), 64'd0);
         chk("rst_ack2", 64'(bus.write_ack2), 64'd0);
         chk("rst_conflict", 64'(bus.conflict), 64'd0);
      end
      drv(1, 0, 1, 19'h00010);
      drain();
      chk("single_addr1", 64'(bus.read_address1), 64'h10);
      chk("single_addr2", 64'(bus.read_address2), 64'h0);
      foreach (tbl[i]) begin
         drv(tbl[i].re, tbl[i].we, tbl[i].in, tbl[i].a);
         chk($sformatf("tbl%0d_pending", i), 64'(bus.pending), 64'(tbl[i].pend));
         chk($sformatf("tbl%0d_ack1", i), 64'(bus.write_ack1), 64'(tbl[i].ack1));
         chk($sformatf("tbl%0d_ack2", i), 64'(bus.write_ack2), 64'(tbl[i].ack2));
         chk($sformatf("tbl%0d_conflict", i), 64'(bus.conflict), 64'd0);
      end
      drain();
      drv(1, 1, 1, 19'h00020);
      chk("conflict_set", 64'(bus.conflict), 64'd1);
      repeat (2) begin
         drv(0, 0, 0, '0);
         chk("conflict_ack1", 64'(bus.write_ack1), 64'd0);
         chk("conflict_ack2", 64'(bus.write_ack2), 64'd0);
      end
      drain();
      chk("conflict_sticky", 64'(bus.conflict), 64'd1);
      chk("conflict_rd_addr", 64'(bus.read_address1), 64'h20);
      drv(1, 0, 1, 19'h5);
      drv(1, 0, 0, 19'h6);
      chk("midflight_pending", 64'(bus.pending), 64'd2);
      bus.read_enable = 1'b0;
      #2 rst = 1'b1;
      q.delete();
      m_d1 = '0; m_d2 = '0; m_a1 = '0; m_a2 = '0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_pending", 64'(bus.pending), 64'd0);
      chk("rst_conflict_clr", 64'(bus.conflict), 64'd0);
      repeat (10) drv(0, 0, 0, '0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/sram_return_router.md
# sram_return_router

Return path for the shared frame-buffer SRAM. It tracks every access issued through the request multiplexer and routes each SRAM read word back to the client that issued it (client 1 = testbench/init side, client 2 = GPU datapath). It also generates per-client write acknowledges and reports in-flight status, so `init` can be switched only when the path is idle. It sits between the SRAM read-data output and the two clients, in parallel with the request multiplexer.

## Interface
Parameters:
- `DATA_W`, 1536: SRAM word width.
- `ADDR_W`, 19: SRAM address width.
- `READ_LATENCY`, 2: cycles from a sampled read request to valid SRAM data; legal range 1..8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `init` in 1: owner select for the current request; 1 = client 1, 0 = client 2. Same signal that drives the request mux.
- `read_enable` in 1: muxed read request into the SRAM.
- `write_enable` in 1: muxed write request into the SRAM.
- `address` in ADDR_W: muxed SRAM address.
- `sram_read_data` in DATA_W: SRAM read-data bus.
- `read_data1`, `read_data2` out DATA_W: last word returned to each client; held until that client's next return.
- `read_address1`, `read_address2` out ADDR_W: address of the word currently held in `read_dataN`.
- `read_valid1`, `read_valid2` out 1: one-cycle pulse when `read_dataN` is updated.
- `write_ack1`, `write_ack2` out 1: one-cycle write-complete pulse.
- `pending` out 4: number of reads in flight.
- `idle` out 1: high when `pending == 0`.
- `conflict` out 1: sticky error flag, set when read and write are requested in the same cycle.

## Operation
- Each cycle the block samples `{read_enable, write_enable, init, address}`.
- A read pushes a tag `{valid=1, owner=init, address}` into a tag pipeline `READ_LATENCY` deep. A cycle without a read pushes `valid=0`.
- When a valid tag reaches the pipeline end, `sram_read_data` is captured into the owning client's `read_data`/`read_address` register, and that client's `read_valid` pulses. The other client's outputs are unchanged.
- Owner is bound at issue time. Toggling `init` while reads are in flight is legal, and each word still returns to its issuer.
- A write with no read sets `write_ackN` for the owning client one cycle later. The SRAM write completes in one cycle.
- Read and write in the same cycle: the read is tracked, the write is not acked, and `conflict` is set. `conflict` clears only on `rst`.
- `pending` counts up on issue and down on retire. Issue and retire in the same cycle leave it unchanged. It never exceeds `READ_LATENCY` (8 max fits in 4 bits).

## Timing
- Read sampled at edge k: `sram_read_data` is captured at edge k+`READ_LATENCY`, and `read_validN` is high for the cycle following that edge.
- Back-to-back reads every cycle are supported, giving one return per cycle with no bubbles.
- Write sampled at edge k: `write_ackN` is high for the cycle following edge k+1.
- `pending` and `idle` are registered and reflect the state after each edge.
- Reset values: all `read_data*` and `read_address*` = 0; all `read_valid*` and `write_ack*` = 0; `pending` = 0; `idle` = 1; `conflict` = 0; tag pipeline fully invalid.
- Reset mid-operation: in-flight tags are discarded and no late `read_valid` is produced after `rst` deasserts.

## Structure
- Shared package `sram_port_pkg` holds:
  - `DATA_W` and `ADDR_W` constants (shared with the request multiplexer).
  - `owner_t` enum: `OWNER_1` for init high, `OWNER_2` for init low.
  - `ret_tag_t` struct: `{valid, owner_t owner, logic [ADDR_W-1:0] addr}`.
- One sub-module, `latency_tag_pipe`: a parameterised shift register of `ret_tag_t` with asynchronous reset, emitting the retiring tag. The top level holds the capture registers, ack logic, counter and conflict flag.

## Test plan
- Reset then idle: `rst` pulse → all outputs at their reset values, `idle` = 1, no pulses over 20 cycles.
- Single read, `init`=1, address 0x00010, data 0xA5 pattern at edge k+2 (L=2) → `read_valid1` pulses at k+2 with `read_data1` = pattern and `read_address1` = 0x00010; client 2 outputs unchanged.
- Four back-to-back reads alternating `init` 1,0,1,0 at addresses 0..3 → four consecutive returns alternating client 1 and client 2 with the matching addresses; `pending` peaks at 2 and then returns to 0.
- Write with `init`=0 → `write_ack2` is high exactly one cycle after the write edge; `write_ack1` stays 0 and `pending` stays 0.
- Read and write asserted together → `conflict` = 1 and stays high, no write ack, and the read returns normally.
- Reads issued, then `rst` asserted asynchronously mid-flight and released → `pending` = 0, and no `read_valid*` pulse occurs afterwards.
